// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared widths, lane ratio helpers and datapath types for the FIFO drain stream.
package fifo_stream_pkg;
    localparam int IN_W_DEF  = 128;
    localparam int OUT_W_DEF = 32;

    function automatic int calc_ratio(input int iw, input int ow);
        return iw / ow;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RATIO = calc_ratio(IN_W_DEF, OUT_W_DEF);

    typedef logic [idx_w(RATIO)-1:0] lane_idx_t;
    typedef logic [IN_W_DEF-1:0]     word_t;
    typedef logic [OUT_W_DEF-1:0]    beat_t;
endpackage

// File: rtl/rd_return_buf.sv
// rd_return_buf: issues credit-limited FIFO reads and parks returning words in a circular buffer.
module rd_return_buf
    import fifo_stream_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_fifo_empty,
    output logic            o_fifo_rden,
    input  logic [IN_W-1:0] i_fifo_rddata,
    input  logic            i_pop,
    output logic [IN_W-1:0] o_head,
    output logic            o_valid,
    output logic            o_busy
);
    localparam int PW = idx_w(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + RD_LAT + 1) + 1;

    logic [RD_LAT-1:0] sr_q, sr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d, inflight;
    logic [IN_W-1:0]   mem_q [BUF_DEPTH];
    logic [IN_W-1:0]   mem_d [BUF_DEPTH];
    logic              tail;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reads are only issued while every outstanding word is guaranteed a buffer slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(sr_q[i]);
        tail        = sr_q[RD_LAT-1];
        o_fifo_rden = rst && !i_fifo_empty && (inflight + cnt_q < CW'(BUF_DEPTH));
        sr_d        = (sr_q << 1) | RD_LAT'(o_fifo_rden);
        mem_d       = mem_q;
        if (tail) mem_d[wr_ptr_q] = i_fifo_rddata;
        wr_ptr_d    = tail ? wrap_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = i_pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d       = cnt_q + CW'(tail) - CW'(i_pop);
        o_valid     = cnt_q != '0;
        o_head      = mem_q[rd_ptr_q];
        o_busy      = (inflight != '0) || o_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            sr_q     <= sr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assert property (@(posedge clk) disable iff (!rst) cnt_q <= CW'(BUF_DEPTH));
endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains wide FIFO words and serializes them into narrow valid/ready beats,
// least-significant lane first, counting fully delivered words.
module fifo_rd_streamer
    import fifo_stream_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_fifo_rden,
    input  logic [IN_W-1:0]  i_fifo_rddata,
    input  logic             i_fifo_empty,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic             o_busy,
    output logic [31:0]      o_word_cnt
);
    localparam int R  = calc_ratio(IN_W, OUT_W);
    localparam int LW = idx_w(R);

    logic [IN_W-1:0] head;
    logic            valid, hs, pop, lane_last;
    logic [LW-1:0]   lane_q, lane_d;
    logic [31:0]     word_cnt_q, word_cnt_d;

    rd_return_buf #(
        .IN_W     (IN_W),
        .RD_LAT   (RD_LAT),
        .BUF_DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rden  (o_fifo_rden),
        .i_fifo_rddata(i_fifo_rddata),
        .i_pop        (pop),
        .o_head       (head),
        .o_valid      (valid),
        .o_busy       (o_busy)
    );

    // The head word leaves the buffer only once its final lane is accepted.
    always_comb begin
        lane_last  = lane_q == LW'(R - 1);
        hs         = valid && i_ready;
        pop        = hs && lane_last;
        lane_d     = hs ? (lane_last ? '0 : lane_q + 1'b1) : lane_q;
        word_cnt_d = word_cnt_q + 32'(pop);
        o_valid    = valid;
        o_last     = valid && lane_last;
        o_data     = valid ? head[lane_q*OUT_W +: OUT_W] : '0;
        o_word_cnt = word_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            lane_q     <= lane_d;
            word_cnt_q <= word_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: table vectors, directed corner sequences and a randomized run against a
// FIFO-order beat scoreboard.
module tb_fifo_rd_streamer;
    import fifo_stream_pkg::*;

    localparam int D = 2;

    typedef struct packed {
        word_t         w;
        beat_t [0:3]   e;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b0, i_ready = 1'b0, force_empty = 1'b0;
    logic        o_fifo_rden, i_fifo_empty, o_valid, o_last, o_busy;
    word_t       i_fifo_rddata = '0;
    beat_t       o_data;
    logic [31:0] o_word_cnt;

    word_t mem [512];
    int    wr_n = 0, rd_n = 0, exp_w = 0, lane_m = 0, done = 0;
    int    n_cmp = 0, n_fail = 0;
    logic  stall_p = 1'b0, last_p = 1'b0;
    beat_t data_p = '0;
    vec_t  tbl [4];

    assign i_fifo_empty = force_empty || (rd_n == wr_n);

    always #5 clk = ~clk;

    fifo_rd_streamer #(.IN_W(128), .OUT_W(32), .RD_LAT(1), .BUF_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .o_fifo_rden  (o_fifo_rden),
        .i_fifo_rddata(i_fifo_rddata),
        .i_fifo_empty (i_fifo_empty),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_word_cnt   (o_word_cnt)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input word_t w);
        mem[wr_n] = w;
        wr_n++;
    endtask

    function automatic word_t rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drain(input string nm);
        for (int k = 0; k < 300 && !(rd_n == wr_n && !o_busy); k++) @(negedge clk);
        chk(nm, (rd_n == wr_n) && !o_busy, 1);
    endtask

    // FIFO with one cycle of registered read latency.
    always @(posedge clk) begin
        if (o_fifo_rden) begin
            i_fifo_rddata <= mem[rd_n];
            rd_n          <= rd_n + 1;
        end
    end

    // Scoreboard: beats must follow FIFO order, lane 0 first; words read before a reset are lost.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            exp_w   = rd_n;
            lane_m  = 0;
            done    = 0;
            stall_p = 1'b0;
        end else begin
            chk("word_cnt", o_word_cnt, done);
            chk("credit", (rd_n - exp_w) <= D, 1);
            chk("busy", o_busy, rd_n != exp_w);
            if (o_fifo_rden) chk("rden_on_empty", i_fifo_empty, 0);
            if (o_valid) chk("valid_without_read", exp_w < rd_n, 1);
            else chk("last_idle", o_last, 0);
            if (stall_p) begin
                chk("hold_data", o_data, data_p);
                chk("hold_last", o_last, last_p);
            end
            if (o_valid && i_ready) begin
                chk("beat_data", o_data, mem[exp_w][lane_m*32 +: 32]);
                chk("beat_last", o_last, lane_m == 3);
                if (lane_m == 3) begin
                    lane_m = 0;
                    exp_w++;
                    done++;
                end else lane_m++;
            end
            stall_p = o_valid && !i_ready;
            data_p  = o_data;
            last_p  = o_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int    nr, nb, first, lastc, bz, k;
        beat_t got [4];
        logic  gl [4];
        word_t ws [3];
        word_t w;
        tbl[0] = '{w: 128'h44444444_33333333_22222222_11111111,
                   e: {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}};
        tbl[1] = '{w: 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF,
                   e: {32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF}};
        tbl[2] = '{w: 128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
                   e: {32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF}};
        tbl[3] = '{w: 128'h80000000_00000001_7FFFFFFF_FFFFFFFE,
                   e: {32'hFFFFFFFE, 32'h7FFFFFFF, 32'h00000001, 32'h80000000}};

        // Reset held with a non-empty FIFO
        push(tbl[0].w);
        repeat (3) @(negedge clk);
        chk("rst_rden", o_fifo_rden, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_wcnt", o_word_cnt, 0);
        chk("rst_data", o_data, 0);
        chk("rst_last", o_last, 0);
        @(posedge clk); #1;
        force_empty = 1'b1;
        rst         = 1'b1;
        i_ready     = 1'b1;

        // Single-word vectors
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i != 0) push(tbl[i].w);
            force_empty = 1'b0;
            nr = 0; nb = 0; first = -1; lastc = -1;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (o_fifo_rden) nr++;
                if (o_valid && i_ready) begin
                    if (nb == 0) first = c;
                    if (nb < 4) begin
                        got[nb] = o_data;
                        gl[nb]  = o_last;
                    end
                    nb++;
                    lastc = c;
                end
            end
            chk("tbl_rden_pulses", nr, 1);
            chk("tbl_latency", first, 2);
            chk("tbl_beats", nb, 4);
            chk("tbl_contig", lastc - first, 3);
            for (int j = 0; j < 4; j++) begin
                chk("tbl_beat", got[j], tbl[i].e[j]);
                chk("tbl_last", gl[j], j == 3);
            end
            chk("tbl_wcnt", o_word_cnt, i + 1);
        end

        // Streaming eight words
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) push(rnd_word());
        nb = 0; first = -1; lastc = -1; bz = -1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (o_valid) begin
                if (first < 0) first = c;
                lastc = c;
                nb++;
            end else if (first >= 0 && c == lastc + 1) bz = o_busy;
        end
        chk("stream_beats", nb, 32);
        chk("stream_contig", lastc - first, 31);
        chk("stream_wcnt", o_word_cnt, 12);
        chk("stream_busy_fall", bz, 0);

        // Backpressure while lane 1 is presented
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            ws[i] = rnd_word();
            push(ws[i]);
        end
        for (k = 0; k < 20 && !o_valid; k++) @(negedge clk);
        chk("bp_start", o_valid, 1);
        @(posedge clk); #1;
        i_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("bp_hold", o_data, ws[0][63:32]);
        end
        chk("bp_rden_stops", o_fifo_rden, 0);
        chk("bp_busy", o_busy, 1);
        @(posedge clk); #1;
        i_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_valid && i_ready && nb < 11) begin
                chk("bp_resume", o_data, ws[(nb + 1) / 4][((nb + 1) % 4)*32 +: 32]);
                nb++;
            end
        end
        chk("bp_count", nb, 11);
        drain("bp_drain");
        chk("bp_wcnt", o_word_cnt, 15);

        // Empty flag held high
        @(posedge clk); #1;
        force_empty = 1'b1;
        push(rnd_word());
        push(rnd_word());
        nr = 0; nb = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_fifo_rden) nr++;
            if (o_valid) nb++;
        end
        chk("empty_rden", nr, 0);
        chk("empty_valid", nb, 0);
        @(posedge clk); #1;
        force_empty = 1'b0;
        drain("empty_drain");
        chk("empty_wcnt", o_word_cnt, 17);

        // Asynchronous reset during lane 2
        @(posedge clk); #1;
        push(rnd_word());
        push(rnd_word());
        for (k = 0; k < 20 && !o_valid; k++) @(negedge clk);
        chk("mid_start", o_valid, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rden", o_fifo_rden, 0);
        chk("mid_valid", o_valid, 0);
        chk("mid_busy", o_busy, 0);
        chk("mid_wcnt", o_word_cnt, 0);
        chk("mid_data", o_data, 0);
        chk("mid_last", o_last, 0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        w = rnd_word();
        push(w);
        for (k = 0; k < 20 && !o_valid; k++) @(negedge clk);
        chk("mid_first_beat", o_data, w[31:0]);
        chk("mid_first_wcnt", o_word_cnt, 0);
        drain("mid_drain");
        chk("mid_end_wcnt", o_word_cnt, 1);

        // Randomized traffic and backpressure
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && wr_n < 500) push(rnd_word());
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_streamer.md
Name: fifo_rd_streamer

Overview:
- Downstream drain stage for the 128-bit synchronous FIFO.
- Issues read enables against the FIFO's empty flag and absorbs the FIFO's registered read latency in a small return buffer.
- Serializes each 128-bit word into OUT_W-bit beats on a valid/ready stream, least-significant lane first.
- Feeds the narrow egress datapath and marks the last lane of each word.

Parameters:
- IN_W, 128: FIFO word width; must be an integer multiple of OUT_W.
- OUT_W, 32: output beat width.
- RD_LAT, 1: cycles from FIFO read enable to valid read data; must be ≥1.
- BUF_DEPTH, 2: return-buffer entries; must be ≥ RD_LAT+1 for full throughput.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- o_fifo_rden  out  1  read enable to the FIFO.
- i_fifo_rddata  in  IN_W  FIFO read data, valid RD_LAT cycles after o_fifo_rden.
- i_fifo_empty  in  1  FIFO empty flag; must be exact for the current cycle.
- o_data  out  OUT_W  output beat.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  sink accepts the beat.
- o_last  out  1  current beat is the final lane of its word.
- o_busy  out  1  a word is in flight or buffered.
- o_word_cnt  out  32  count of fully delivered words; wraps at 2^32.

Behaviour:
- Constants: RATIO = IN_W/OUT_W; lane index width is clog2(RATIO).
- Reset (rst=0, asynchronous):
  - inflight, buf_cnt, pointers, lane and o_word_cnt clear to 0.
  - o_fifo_rden=0, o_valid=0, o_last=0, o_busy=0, o_data=0.
  - Words already read from the FIFO are discarded.
- Credit rule (combinational):
  - o_fifo_rden = !i_fifo_empty && (inflight + buf_cnt < BUF_DEPTH).
  - inflight = number of ones in an RD_LAT-stage shift register of past read enables.
- Return path:
  - When the shift-register tail is 1, i_fifo_rddata is written to buf[wr_ptr] at the next edge.
  - wr_ptr then increments, wrapping at BUF_DEPTH-1 → 0.
  - Overflow cannot occur by construction; the assertion buf_cnt ≤ BUF_DEPTH must hold.
- Output:
  - o_valid = (buf_cnt != 0).
  - o_data = buf[rd_ptr][lane*OUT_W +: OUT_W].
  - o_last = o_valid && (lane == RATIO-1).
- Handshake (o_valid && i_ready):
  - If lane < RATIO-1: lane++.
  - Otherwise: lane returns to 0, rd_ptr advances with wrap, buf_cnt is decremented and o_word_cnt is incremented.
- Stability: while o_valid && !i_ready, o_data, o_last and lane hold unchanged.
- Simultaneous capture and pop in the same cycle: buf_cnt is unchanged and both pointers advance.
- Latency: the first beat of a word has o_valid high RD_LAT+1 cycles after the cycle in which its o_fifo_rden was high.
- Throughput: with i_ready held at 1 and the FIFO non-empty, the block emits one beat per cycle with no bubbles after the first word.
- o_busy = (inflight != 0) || (buf_cnt != 0).
- No state machine beyond the lane counter: IDLE means buf_cnt == 0; SEND means buf_cnt > 0.

Decomposition:
- Package fifo_stream_pkg holds:
  - the IN_W and OUT_W defaults;
  - RATIO, computed as a localparam function;
  - the lane_idx_t typedef;
  - the word_t and beat_t typedefs.
- Sub-module rd_return_buf holds the read-enable latency shift register, the circular BUF_DEPTH buffer and the credit computation.
- The top level holds the lane serializer and the word counter.

Test Plan:
- Reset: hold rst=0 with the FIFO non-empty → o_fifo_rden=0, o_valid=0, o_busy=0, o_word_cnt=0.
- Single word: FIFO supplies 0x44444444_33333333_22222222_11111111 with i_ready=1 → exactly one rden pulse; two cycles later 4 consecutive beats 0x11111111, 0x22222222, 0x33333333, 0x44444444; o_last on the 4th beat only; o_word_cnt=1.
- Streaming: 8 words available with i_ready=1 → 32 contiguous valid beats with no gap after the first; o_word_cnt=8; o_busy falls after the final beat.
- Backpressure: drop i_ready for 6 cycles after lane 1 → o_data holds the lane-1 value; at most BUF_DEPTH words are outstanding (rden stops); the stream resumes at lane 1 with no loss or duplication.
- Empty: i_fifo_empty=1 throughout → o_fifo_rden never asserts; o_valid stays 0.
- Mid-word reset: assert rst=0 during lane 2 → all outputs clear immediately, without waiting for a clock edge; after release, the next word starts at lane 0 and o_word_cnt=0.
